// File: rtl/adc_frame_align.sv
// Bitslip training controller: slips the ISERDES word boundary until the frame-clock
// word matches FRAME_PATTERN, then watches for loss of alignment and retrains.
module adc_frame_align #(
  parameter logic [7:0] FRAME_PATTERN = 8'hF0,
  parameter int         LOCK_COUNT    = 16,
  parameter int         LOSS_COUNT    = 4,
  parameter int         SLIP_WAIT     = 4,
  parameter int         MAX_SLIPS     = 8
) (
  input  logic       adc_clk,
  input  logic       cpu_resetn,
  input  logic       align_en,
  input  logic [7:0] frmData,
  output logic       bitslip,
  output logic       aligned,
  output logic       align_err,
  output logic [3:0] slip_count,
  output logic [7:0] relock_cnt
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);

  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [MW-1:0] MATCH_FULL = MW'(LOCK_COUNT);
  localparam logic [LW-1:0] MISS_LAST  = LW'(LOSS_COUNT - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(SLIP_WAIT - 1);
  localparam logic [3:0]    SLIP_MAX   = 4'(MAX_SLIPS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SLIP,
    ST_WAIT,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  state_t          state, state_nxt;
  logic [MW-1:0]   match_cnt, match_nxt;
  logic [LW-1:0]   miss_cnt, miss_nxt;
  logic [WW-1:0]   wait_cnt, wait_nxt;
  logic [3:0]      slip_nxt;
  logic [7:0]      relock_nxt;
  logic            frame_ok;

  assign frame_ok = (frmData == FRAME_PATTERN);

  // slip_count is bumped on entry to SLIP so it already includes the pulse being issued
  always_comb begin
    state_nxt  = state;
    match_nxt  = match_cnt;
    miss_nxt   = miss_cnt;
    wait_nxt   = wait_cnt;
    slip_nxt   = slip_count;
    relock_nxt = relock_cnt;
    if (!align_en) begin
      state_nxt = ST_IDLE;
      match_nxt = '0;
      miss_nxt  = '0;
      wait_nxt  = '0;
      slip_nxt  = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_nxt = ST_CHECK;
          match_nxt = '0;
          miss_nxt  = '0;
          slip_nxt  = '0;
        end
        ST_CHECK: begin
          if (frame_ok) begin
            if (match_cnt == MATCH_LAST) begin
              state_nxt = ST_LOCKED;
              match_nxt = MATCH_FULL;
              miss_nxt  = '0;
            end else begin
              match_nxt = match_cnt + 1'b1;
            end
          end else if (slip_count == SLIP_MAX) begin
            state_nxt = ST_FAIL;
          end else begin
            state_nxt = ST_SLIP;
            match_nxt = '0;
            slip_nxt  = slip_count + 1'b1;
          end
        end
        ST_SLIP: begin
          state_nxt = ST_WAIT;
          wait_nxt  = '0;
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state_nxt = ST_CHECK;
            match_nxt = '0;
          end else begin
            wait_nxt = wait_cnt + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (frame_ok) begin
            miss_nxt = '0;
          end else if (miss_cnt == MISS_LAST) begin
            state_nxt = ST_CHECK;
            miss_nxt  = '0;
            match_nxt = '0;
            slip_nxt  = '0;
            if (relock_cnt != 8'hFF) relock_nxt = relock_cnt + 1'b1;
          end else begin
            miss_nxt = miss_cnt + 1'b1;
          end
        end
        ST_FAIL: begin
          state_nxt = ST_FAIL;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Status outputs are decoded from the next state so they are registered yet track state exactly
  always_ff @(posedge adc_clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state      <= ST_IDLE;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      wait_cnt   <= '0;
      slip_count <= '0;
      relock_cnt <= '0;
      bitslip    <= 1'b0;
      aligned    <= 1'b0;
      align_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      match_cnt  <= match_nxt;
      miss_cnt   <= miss_nxt;
      wait_cnt   <= wait_nxt;
      slip_count <= slip_nxt;
      relock_cnt <= relock_nxt;
      bitslip    <= (state_nxt == ST_SLIP);
      aligned    <= (state_nxt == ST_LOCKED);
      align_err  <= (state_nxt == ST_FAIL);
    end
  end

endmodule
